regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register file with a per-entry write-reservation scoreboard. It is the multi-entry, multi-read-port successor to the single reserve/writeback cell.
- Each entry holds data, a busy bit and the reserving producer's tag. Writeback releases the reservation only when its tag matches, so a stale producer cannot clear a newer reservation (WAW-safe).
- Sits between decode/issue (reserve, operand read) and the writeback bus; flush supports mispredict recovery.

Parameters:
- NREG, 32, number of entries.
- AW, 5, address width; NREG <= 2**AW.
- DW, `WORD, data width.
- TW, 4, reservation tag width.
- NRD, 2, number of read ports.
- ZERO_REG, 1, if 1 entry 0 reads 0, is never busy, and ignores reserve/writeback.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr_i  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data_o  out  NRD*DW  read data.
- rd_busy_o  out  NRD  busy bit of addressed entry.
- rd_tag_o  out  NRD*TW  tag of addressed entry (valid when busy).
- rsv_valid_i  in  1  reserve request.
- rsv_addr_i  in  AW  entry to reserve.
- rsv_tag_i  in  TW  producer tag.
- wb_valid_i  in  1  writeback request.
- wb_addr_i  in  AW  entry to write.
- wb_tag_i  in  TW  producer tag.
- wb_data_i  in  DW  data to write.
- flush_i  in  1  clear all reservations.
- busy_count_o  out  $clog2(NREG)+1  number of busy entries.

Behaviour:
- Reset, asynchronous on rst low: all data 0, busy 0, tags 0. Consequently rd_data_o 0, rd_busy_o 0, rd_tag_o 0, busy_count_o 0.
- Reads: combinational from current register state, zero latency. Out-of-range address (>= NREG) returns data 0, busy 0, tag 0.
- Reserve: at the clock edge with rsv_valid_i, entry busy <= 1 and tag <= rsv_tag_i.
  - Reserving an already-busy entry overwrites its tag (rename).
- Writeback: at the clock edge with wb_valid_i, data <= wb_data_i unconditionally.
  - busy <= 0 only if the entry is busy and its stored tag == wb_tag_i.
  - A tag mismatch leaves busy and tag unchanged.
- Reserve and writeback to the same entry in the same cycle: data written, reserve wins (busy 1, tag = rsv_tag_i).
- Reserve and writeback to different entries: independent.
- Flush: at the clock edge all busy <= 0.
  - Flush has priority over a same-cycle reserve; that reservation is dropped.
  - A same-cycle writeback still writes data.
- Entry 0 with ZERO_REG=1: reserve and writeback are ignored, and the entry always reads data 0, busy 0.
- busy_count_o always equals the popcount of the busy vector in the current cycle. It is maintained as a registered counter (+1, -1 or 0 per edge; only one reserve and one writeback per cycle). Flush sets it to 0.
- Reset mid-operation: immediate return to reset state; pending reservations are lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose address equals wb_addr_i while wb_valid_i is high sees the written data in the same cycle.
  - rd_data_o = wb_data_i.
  - rd_busy_o = post-writeback busy (0 if the tag matched and there is no same-cycle reserve to that entry).
  - rd_tag_o = stored tag.
  - Bypass is suppressed for entry 0 when ZERO_REG=1.
- Undefined: reads see pre-edge state only; written data becomes visible the cycle after the writeback.

Decomposition:
- include/params.vh holds `WORD and default `NREG, `REG_AW and `RSV_TW defines, shared with decode and writeback.
- Sub-module regfile_entry holds one entry's data, busy and tag registers with clk/rst. Its inputs are decoded per-entry rsv_en, wb_en, tag_match and flush; its outputs are data, busy and tag.
- The top level handles address decode, tag compare, read muxing, bypass and the busy counter.

Test Plan:
- Reset: drive rst low mid-run after reserving entries 3 and 7 -> all reads data 0, busy 0; busy_count_o 0.
- Reserve, then writeback:
  - Reserve r5 tag 2 -> next cycle rd_busy 1, rd_tag 2, count 1.
  - wb r5 tag 2 data 0xDEADBEEF -> next cycle data 0xDEADBEEF, busy 0, count 0.
- Stale writeback:
  - Reserve r4 tag 1, then reserve r4 tag 3.
  - wb r4 tag 1 data 0x11 -> data 0x11, busy stays 1, tag 3, count 1.
  - wb r4 tag 3 -> busy 0.
- Same-cycle reserve and writeback on r6: reserve tag 5 with wb tag 4 data 0x22, r6 previously busy with tag 4 -> data 0x22, busy 1, tag 5, count unchanged.
- Flush and zero register:
  - Reserve r1, r2, r3; then flush in the same cycle as reserve r9 -> all busy 0, count 0, r9 not busy.
  - wb r0 data 0xFF -> r0 reads 0.
- Bypass:
  - With REGFILE_BYPASS_EN, port 1 reads r8 while wb r8 data 0x1234 -> rd_data_o 0x1234 in the same cycle.
  - Without the macro -> old value that cycle, 0x1234 next cycle.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared widths/defaults for the scoreboarded register file
`ifndef WORD
`define WORD 32
`endif
`ifndef NREG
`define NREG 32
`endif
`ifndef REG_AW
`define REG_AW 5
`endif
`ifndef RSV_TW
`define RSV_TW 4
`endif

package regfile_scoreboard_pkg;
  localparam int DEF_DW   = `WORD;
  localparam int DEF_NREG = `NREG;
  localparam int DEF_AW   = `REG_AW;
  localparam int DEF_TW   = `RSV_TW;
endpackage

// File: rtl/regfile_scoreboard_entry.sv
// rtl/regfile_scoreboard_entry.sv - one entry: data, busy bit and reserving producer tag
module regfile_entry #(
  parameter int DW = 32,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rsv_en_i,
  input  logic [TW-1:0] rsv_tag_i,
  input  logic          wb_en_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          tag_match_i,
  input  logic          flush_i,
  output logic [DW-1:0] data_o,
  output logic          busy_o,
  output logic [TW-1:0] tag_o
);
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic [TW-1:0] tag_q, tag_d;

  // Priority: flush drops everything, then reserve, then a tag-matched release.
  always_comb begin
    data_d = wb_en_i ? wb_data_i : data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (rsv_en_i) begin
      busy_d = 1'b1;
      tag_d  = rsv_tag_i;
    end else if (wb_en_i && busy_q && tag_match_i) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
  assign tag_o  = tag_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with WAW-safe reservation scoreboard
// Optional same-cycle writeback bypass on reads: define REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int TW       = DEF_TW,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*AW-1:0]      rd_addr_i,
  output logic [NRD*DW-1:0]      rd_data_o,
  output logic [NRD-1:0]         rd_busy_o,
  output logic [NRD*TW-1:0]      rd_tag_o,
  input  logic                   rsv_valid_i,
  input  logic [AW-1:0]          rsv_addr_i,
  input  logic [TW-1:0]          rsv_tag_i,
  input  logic                   wb_valid_i,
  input  logic [AW-1:0]          wb_addr_i,
  input  logic [TW-1:0]          wb_tag_i,
  input  logic [DW-1:0]          wb_data_i,
  input  logic                   flush_i,
  output logic [$clog2(NREG):0]  busy_count_o
);
  localparam int CW = $clog2(NREG) + 1;

  logic [NREG-1:0] rsv_en, wb_en, tag_match, busy_vec;
  logic [DW-1:0]   data_arr [NREG];
  logic [TW-1:0]   tag_arr  [NREG];
  logic            inc, dec;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   ra;

  always_comb begin
    rsv_en    = '0;
    wb_en     = '0;
    tag_match = '0;
    for (int i = 0; i < NREG; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        rsv_en[i] = rsv_valid_i && (rsv_addr_i == AW'(i));
        wb_en[i]  = wb_valid_i && (wb_addr_i == AW'(i));
      end
      tag_match[i] = (tag_arr[i] == wb_tag_i);
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_ent
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign data_arr[i] = '0;
      assign busy_vec[i] = 1'b0;
      assign tag_arr[i]  = '0;
    end else begin : g_reg
      regfile_entry #(.DW(DW), .TW(TW)) u_entry (
        .clk         (clk),
        .rst         (rst),
        .rsv_en_i    (rsv_en[i]),
        .rsv_tag_i   (rsv_tag_i),
        .wb_en_i     (wb_en[i]),
        .wb_data_i   (wb_data_i),
        .tag_match_i (tag_match[i]),
        .flush_i     (flush_i),
        .data_o      (data_arr[i]),
        .busy_o      (busy_vec[i]),
        .tag_o       (tag_arr[i])
      );
    end
  end

  // A release is lost when the same entry is re-reserved this cycle.
  assign inc = |(rsv_en & ~busy_vec);
  assign dec = |(wb_en & busy_vec & tag_match & ~rsv_en);
  assign count_d = flush_i ? '0 : (count_q + CW'(inc) - CW'(dec));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end
  assign busy_count_o = count_q;

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rd_tag_o  = '0;
    ra        = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr_i[k*AW +: AW];
      if (32'(ra) < NREG) begin
        rd_data_o[k*DW +: DW] = data_arr[ra];
        rd_busy_o[k]          = busy_vec[ra];
        rd_tag_o[k*TW +: TW]  = tag_arr[ra];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid_i && ra == wb_addr_i && !(ZERO_REG != 0 && ra == '0)) begin
          rd_data_o[k*DW +: DW] = wb_data_i;
          rd_busy_o[k]          = busy_vec[ra] & ~(tag_match[ra] & ~rsv_en[ra]);
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - vector table + scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr_i = '0;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic [7:0]  rd_tag_o;
  logic        rsv_valid_i = 1'b0;
  logic [4:0]  rsv_addr_i = '0;
  logic [3:0]  rsv_tag_i = '0;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [3:0]  wb_tag_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        flush_i = 1'b0;
  logic [5:0]  busy_count_o;

  int n_cmp = 0;
  int n_err = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o), .rd_tag_o(rd_tag_o), .rsv_valid_i(rsv_valid_i),
    .rsv_addr_i(rsv_addr_i), .rsv_tag_i(rsv_tag_i), .wb_valid_i(wb_valid_i),
    .wb_addr_i(wb_addr_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .busy_count_o(busy_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rv; logic [4:0] ra; logic [3:0] rt;
    logic wv; logic [4:0] wa; logic [3:0] wt; logic [31:0] wd;
    logic fl; logic [4:0] a0; logic [4:0] a1;
    logic [31:0] d0; logic b0; logic [3:0] t0;
    logic [31:0] d1; logic b1; logic [5:0] cnt;
  } vec_t;

  typedef struct {
    logic [31:0] d0; logic b0; logic [3:0] t0;
    logic [31:0] d1; logic b1; logic [5:0] cnt;
  } exp_t;

  vec_t vecs[17];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rsv_valid_i = 1'b0; wb_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " d0"},  rd_data_o[31:0],  e.d0);
    chk({tag, " b0"},  32'(rd_busy_o[0]), 32'(e.b0));
    chk({tag, " t0"},  32'(rd_tag_o[3:0]), 32'(e.t0));
    chk({tag, " d1"},  rd_data_o[63:32], e.d1);
    chk({tag, " b1"},  32'(rd_busy_o[1]), 32'(e.b1));
    chk({tag, " cnt"}, 32'(busy_count_o),  32'(e.cnt));
  endtask

  initial begin
    vecs[0]  = '{1,5,2,  0,0,0,32'h0,        0, 5,0,  32'h0,1,2,        32'h0,0,        1};
    vecs[1]  = '{0,0,0,  1,5,2,32'hDEADBEEF, 0, 5,0,  32'hDEADBEEF,0,2, 32'h0,0,        0};
    vecs[2]  = '{1,4,1,  0,0,0,32'h0,        0, 4,5,  32'h0,1,1,        32'hDEADBEEF,0, 1};
    vecs[3]  = '{1,4,3,  0,0,0,32'h0,        0, 4,5,  32'h0,1,3,        32'hDEADBEEF,0, 1};
    vecs[4]  = '{0,0,0,  1,4,1,32'h11,       0, 4,5,  32'h11,1,3,       32'hDEADBEEF,0, 1};
    vecs[5]  = '{0,0,0,  1,4,3,32'h33,       0, 4,5,  32'h33,0,3,       32'hDEADBEEF,0, 0};
    vecs[6]  = '{1,6,4,  0,0,0,32'h0,        0, 6,4,  32'h0,1,4,        32'h33,0,       1};
    vecs[7]  = '{1,6,5,  1,6,4,32'h22,       0, 6,4,  32'h22,1,5,       32'h33,0,       1};
    vecs[8]  = '{1,1,1,  0,0,0,32'h0,        0, 1,6,  32'h0,1,1,        32'h22,1,       2};
    vecs[9]  = '{1,2,2,  0,0,0,32'h0,        0, 2,1,  32'h0,1,2,        32'h0,1,        3};
    vecs[10] = '{1,3,3,  0,0,0,32'h0,        0, 3,2,  32'h0,1,3,        32'h0,1,        4};
    vecs[11] = '{1,9,6,  0,0,0,32'h0,        1, 9,3,  32'h0,0,0,        32'h0,0,        0};
    vecs[12] = '{0,0,0,  1,0,0,32'hFF,       0, 0,5,  32'h0,0,0,        32'hDEADBEEF,0, 0};
    vecs[13] = '{1,0,7,  0,0,0,32'h0,        0, 0,6,  32'h0,0,0,        32'h22,0,       0};
    vecs[14] = '{0,0,0,  1,7,9,32'h77,       0, 7,0,  32'h77,0,0,       32'h0,0,        0};
    vecs[15] = '{1,10,1, 1,6,5,32'h66,       0, 10,6, 32'h0,1,1,        32'h66,0,       1};
    vecs[16] = '{0,0,0,  1,10,1,32'hAA,      0, 10,6, 32'hAA,0,1,       32'h66,0,       0};

    #12;
    rd_addr_i = {5'd7, 5'd3};
    #1;
    chk("reset d0", rd_data_o[31:0], 32'h0);
    chk("reset busy", 32'(rd_busy_o), 32'h0);
    chk("reset cnt", 32'(busy_count_o), 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      rsv_valid_i = vecs[i].rv; rsv_addr_i = vecs[i].ra; rsv_tag_i = vecs[i].rt;
      wb_valid_i  = vecs[i].wv; wb_addr_i  = vecs[i].wa; wb_tag_i  = vecs[i].wt;
      wb_data_i   = vecs[i].wd; flush_i    = vecs[i].fl;
      rd_addr_i   = {vecs[i].a1, vecs[i].a0};
      sb.push_back('{vecs[i].d0, vecs[i].b0, vecs[i].t0, vecs[i].d1, vecs[i].b1, vecs[i].cnt});
      @(posedge clk);
      #1;
      idle();
      check_sb($sformatf("vec%0d", i));
    end

    @(negedge clk);
    wb_valid_i = 1'b1; wb_addr_i = 5'd8; wb_tag_i = 4'd0; wb_data_i = 32'h1234;
    rd_addr_i = {5'd8, 5'd0};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass same", rd_data_o[63:32], 32'h1234);
`else
    chk("bypass same", rd_data_o[63:32], 32'h0);
`endif
    chk("bypass busy", 32'(rd_busy_o[1]), 32'h0);
    @(posedge clk);
    #1;
    idle();
    chk("bypass next", rd_data_o[63:32], 32'h1234);

    @(negedge clk);
    rsv_valid_i = 1'b1; rsv_addr_i = 5'd3; rsv_tag_i = 4'd3;
    @(negedge clk);
    rsv_addr_i = 5'd7; rsv_tag_i = 4'd7;
    @(posedge clk);
    #1;
    idle();
    rd_addr_i = {5'd7, 5'd3};
    #1;
    chk("pre-reset cnt", 32'(busy_count_o), 32'd2);
    chk("pre-reset busy", 32'(rd_busy_o), 32'h3);
    #1;
    rst = 1'b0;
    #1;
    chk("mid-reset busy", 32'(rd_busy_o), 32'h0);
    chk("mid-reset tag", 32'(rd_tag_o), 32'h0);
    chk("mid-reset cnt", 32'(busy_count_o), 32'h0);
    rd_addr_i = {5'd8, 5'd5};
    #1;
    chk("mid-reset data", 32'(rd_data_o[31:0] | rd_data_o[63:32]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
